frame_draw_sched: RTL and testbench

- Full-frame draw scheduler for the 160x120, 3-bit-colour VGA path.
- Arbitrates among NREQ image sources (MIF ROMs: per-level backgrounds, game-over screen, etc.), grants one source per frame, and scans it pixel by pixel.
- Generates the ROM address, aligns x/y with the ROM read latency, and drives the VGA adapter's x, y, colour and plot inputs.
- Sits between the game-level FSM (requesters) and the vga_adapter.

---
 rtl/frame_draw_sched.sv | 179 +++++++++++++++++
 tb/tb_frame_draw_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_draw_sched.sv
// frame_draw_sched: full-frame draw scheduler for the 160x120 3-bit VGA path.
// Grants one image source per frame by round robin, scans it pixel by pixel,
// issues the shared ROM address and drives the vga_adapter x/y/colour/plot
// inputs after the ROM read latency.
// Optional build macro TRANSPARENT_KEY_EN adds a key_colour input; pixels
// matching it are scanned but not plotted.
module frame_draw_sched #(
  parameter int X_PIXELS = 160,
  parameter int Y_PIXELS = 120,
  parameter int NREQ     = 3,
  parameter int ROM_LAT  = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [3*NREQ-1:0]   rom_q,
`ifdef TRANSPARENT_KEY_EN
  input  logic [2:0]          key_colour,
`endif
  output logic [14:0]         rom_addr,
  output logic [NREQ-1:0]     grant,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [2:0]          colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         state;
  logic [1:0]         rr_ptr;
  logic [1:0]         flush_cnt;
  logic [NREQ-1:0]    grant_nxt;
  logic [1:0]         ptr_nxt;
  int                 sel_idx;

  // stage p0: scan counters and the address they produce
  logic [7:0]         x_p0;
  logic [6:0]         y_p0;
  logic [14:0]        addr_p0;
  logic               vld_p0;

  // stage p1: coordinates delayed to line up with ROM data
  logic [7:0]         x_p1 [ROM_LAT];
  logic [6:0]         y_p1 [ROM_LAT];
  logic [ROM_LAT-1:0] vld_p1;

  logic [2:0]         pix;
  logic               pix_keep;

  assign rom_addr = addr_p0;
  assign vld_p0   = (state == SCAN);

  // Round-robin pick: scan from the pointer upward, nearest requester wins
  always_comb begin
    grant_nxt = '0;
    ptr_nxt   = rr_ptr;
    sel_idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sel_idx = int'(rr_ptr) + k;
      if (sel_idx >= NREQ) sel_idx = sel_idx - NREQ;
      if (req[sel_idx]) begin
        grant_nxt          = '0;
        grant_nxt[sel_idx] = 1'b1;
        ptr_nxt            = (sel_idx == NREQ - 1) ? 2'd0 : 2'(sel_idx + 1);
      end
    end
  end

  // Frame control FSM: arbitration, raster scan counters and flush timing
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= 2'd0;
      grant     <= '0;
      busy      <= 1'b0;
      flush_cnt <= 2'd0;
      x_p0      <= 8'd0;
      y_p0      <= 7'd0;
      addr_p0   <= 15'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant   <= grant_nxt;
            rr_ptr  <= ptr_nxt;
            busy    <= 1'b1;
            x_p0    <= 8'd0;
            y_p0    <= 7'd0;
            addr_p0 <= 15'd0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          addr_p0 <= addr_p0 + 15'd1;
          if (x_p0 == 8'(X_PIXELS - 1)) begin
            x_p0 <= 8'd0;
            if (y_p0 == 7'(Y_PIXELS - 1)) begin
              y_p0      <= 7'd0;
              addr_p0   <= 15'd0;
              flush_cnt <= 2'd0;
              state     <= FLUSH;
            end else begin
              y_p0 <= y_p0 + 7'd1;
            end
          end else begin
            x_p0 <= x_p0 + 8'd1;
          end
        end
        FLUSH: begin
          if (flush_cnt == 2'(ROM_LAT - 1)) state <= DONE;
          else flush_cnt <= flush_cnt + 2'd1;
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // p0 -> p1: coordinate delay line matching the ROM read latency
  always_ff @(posedge clock) begin
    x_p1[0] <= x_p0;
    y_p1[0] <= y_p0;
    for (int i = 1; i < ROM_LAT; i++) begin
      x_p1[i] <= x_p1[i-1];
      y_p1[i] <= y_p1[i-1];
    end
  end

  // p0 -> p1: valid delay line, cleared on reset so no stale plots escape
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_p1 <= '0;
    end else begin
      vld_p1[0] <= vld_p0;
      for (int i = 1; i < ROM_LAT; i++) vld_p1[i] <= vld_p1[i-1];
    end
  end

  // Colour of the granted source from the shared ROM bus
  always_comb begin
    pix = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) pix = rom_q[3*i +: 3];
    end
  end

`ifdef TRANSPARENT_KEY_EN
  assign pix_keep = (pix != key_colour);
`else
  assign pix_keep = 1'b1;
`endif

  // p1 -> outputs: registered VGA drive and end-of-frame pulse
  always_ff @(posedge clock) begin
    if (!reset) begin
      plot   <= 1'b0;
      x      <= 8'd0;
      y      <= 7'd0;
      colour <= 3'd0;
      done   <= 1'b0;
    end else begin
      plot   <= vld_p1[ROM_LAT-1] && pix_keep;
      x      <= x_p1[ROM_LAT-1];
      y      <= y_p1[ROM_LAT-1];
      colour <= pix;
      done   <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_frame_draw_sched.sv
// tb_frame_draw_sched: self-checking bench for frame_draw_sched.
// Reference behaviour: a frame granted at cycle 0 plots pixel n at cycle
// n+ROM_LAT+1 with x=n%160, y=n/160; done pulses one cycle after the last
// plot. Honours TRANSPARENT_KEY_EN with key_colour tied to 0.
module tb_frame_draw_sched;
  localparam int NREQ    = 3;
  localparam int ROM_LAT = 1;
  localparam int XP      = 160;
  localparam int NPIX    = 19200;
  localparam int FULL_K  = NPIX + ROM_LAT + 1;
`ifdef TRANSPARENT_KEY_EN
  localparam int EXP_PLOTS = 16800;
`else
  localparam int EXP_PLOTS = 19200;
`endif

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] rom_q;
  logic [14:0]       rom_addr;
  logic [NREQ-1:0]   grant;
  logic [7:0]        x;
  logic [6:0]        y;
  logic [2:0]        colour;
  logic              plot;
  logic              busy;
  logic              done;
`ifdef TRANSPARENT_KEY_EN
  logic [2:0]        key_colour;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int m_ptr = 0;

  frame_draw_sched #(.X_PIXELS(160), .Y_PIXELS(120), .NREQ(NREQ), .ROM_LAT(ROM_LAT)) dut (
    .clock(clock), .reset(reset), .req(req), .rom_q(rom_q),
`ifdef TRANSPARENT_KEY_EN
    .key_colour(key_colour),
`endif
    .rom_addr(rom_addr), .grant(grant), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM image: word at address a of source s is (a + 3s) mod 8
  function automatic logic [2:0] rom_word(input int src, input int a);
    return 3'((a + 3 * src) & 7);
  endfunction

  function automatic bit keep(input logic [2:0] c);
`ifdef TRANSPARENT_KEY_EN
    return c != key_colour;
`else
    return 1'b1;
`endif
  endfunction

  // Round robin from the spec rules: first requester at or after ptr
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Synchronous ROM model with ROM_LAT cycles of read latency
  logic [14:0] addr_pipe [ROM_LAT];
  always @(posedge clock) begin
    addr_pipe[0] <= rom_addr;
    for (int i = 1; i < ROM_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
  end

  always_comb begin
    rom_q = '0;
    for (int i = 0; i < NREQ; i++) rom_q[3*i +: 3] = rom_word(i, int'(addr_pipe[ROM_LAT-1]));
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input bit ok, input string detail);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, grant == 0 && x == 0 && y == 0 && colour == 0 && plot == 0 &&
          busy == 0 && done == 0 && rom_addr == 0,
          $sformatf("got grant=%b x=%0d y=%0d colour=%0d plot=%b busy=%b done=%b addr=%0d, want all 0",
                    grant, x, y, colour, plot, busy, done, rom_addr));
  endtask

  // Entered at the grant cycle (k=0); checks every cycle up to last_k
  task automatic run_frame(input int src, input int last_k, input bit rand_req);
    int plots, dones, n, ex, ey;
    logic [NREQ-1:0] eg;
    logic [14:0] ea;
    logic [2:0] ec;
    logic eb, ed, ep, win;
    plots = 0;
    dones = 0;
    for (int k = 0; k <= last_k; k++) begin
      if (k > 0) begin
        if (rand_req) req = NREQ'($urandom);
        step();
      end
      eb  = (k <= NPIX + ROM_LAT);
      eg  = eb ? NREQ'(1 << src) : '0;
      ed  = (k == NPIX + ROM_LAT + 1);
      win = (k >= ROM_LAT + 1) && (k <= NPIX + ROM_LAT);
      n   = k - ROM_LAT - 1;
      ex  = win ? n % XP : 0;
      ey  = win ? n / XP : 0;
      ec  = win ? rom_word(src, n) : 3'd0;
      ep  = win && keep(ec);
      ea  = (k < NPIX) ? 15'(k) : 15'd0;
      n_cmp++;
      if (!(grant == eg && busy == eb && done == ed && plot == ep && rom_addr == ea)) begin
        n_bad++;
        $display("FAIL frame_ctl k=%0d: got grant=%b busy=%b done=%b plot=%b addr=%0d want grant=%b busy=%b done=%b plot=%b addr=%0d",
                 k, grant, busy, done, plot, rom_addr, eg, eb, ed, ep, ea);
      end
      if (win) begin
        n_cmp++;
        if (!(x == 8'(ex) && y == 7'(ey) && colour == ec)) begin
          n_bad++;
          $display("FAIL frame_pix n=%0d: got (%0d,%0d) c=%0d want (%0d,%0d) c=%0d",
                   n, x, y, colour, ex, ey, ec);
        end
      end
      plots += int'(plot);
      dones += int'(done);
    end
    if (last_k == FULL_K) begin
      check("plot_count", plots == EXP_PLOTS, $sformatf("got %0d want %0d", plots, EXP_PLOTS));
      check("done_count", dones == 1, $sformatf("got %0d want 1", dones));
    end
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] exp_grant;
  } vec_t;

  initial begin
    vec_t tbl [8];
    int src, stop;
    logic [NREQ-1:0] r;

    tbl[0] = '{3'b000, 3'b000};
    tbl[1] = '{3'b001, 3'b001};
    tbl[2] = '{3'b010, 3'b010};
    tbl[3] = '{3'b100, 3'b100};
    tbl[4] = '{3'b110, 3'b010};
    tbl[5] = '{3'b101, 3'b001};
    tbl[6] = '{3'b011, 3'b001};
    tbl[7] = '{3'b111, 3'b001};

`ifdef TRANSPARENT_KEY_EN
    key_colour = 3'b000;
`endif
    reset = 1'b0;
    req   = '0;
    step(); step(); step();
    check_zero("reset_state");

    // First grant out of reset for each request pattern
    for (int i = 0; i < 8; i++) begin
      reset = 1'b0;
      req   = '0;
      step();
      check_zero("reset_vec");
      reset = 1'b1;
      req   = tbl[i].req;
      step();
      check("table_grant", grant == tbl[i].exp_grant && busy == (tbl[i].exp_grant != 0) &&
            plot == 1'b0 && done == 1'b0 && rom_addr == 15'd0,
            $sformatf("req=%b got grant=%b busy=%b plot=%b done=%b addr=%0d want grant=%b busy=%b",
                      tbl[i].req, grant, busy, plot, done, rom_addr, tbl[i].exp_grant, tbl[i].exp_grant != 0));
      step();
      check("table_addr", rom_addr == ((tbl[i].exp_grant != 0) ? 15'd1 : 15'd0),
            $sformatf("req=%b got addr=%0d", tbl[i].req, rom_addr));
    end

    // Random request patterns, random req churn mid-frame, random abort point
    for (int i = 0; i < 5; i++) begin
      reset = 1'b0;
      req   = '0;
      step();
      reset = 1'b1;
      r     = NREQ'($urandom_range(1, 7));
      req   = r;
      step();
      src   = rr_pick(r, 0);
      stop  = $urandom_range(2, 400);
      run_frame(src, stop, 1'b1);
      reset = 1'b0;
      req   = '0;
      step();
      check_zero("rand_reset");
    end

    // Single-cycle request from source 1: whole frame still drawn
    reset = 1'b1;
    req   = 3'b010;
    step();
    req   = '0;
    run_frame(rr_pick(3'b010, 0), FULL_K, 1'b0);
    step();
    check("idle_after_pulse", grant == 0 && busy == 0 && plot == 0,
          $sformatf("got grant=%b busy=%b plot=%b want 0 0 0", grant, busy, plot));
    step();
    check("idle_after_pulse2", grant == 0 && busy == 0 && done == 0,
          $sformatf("got grant=%b busy=%b done=%b want 0 0 0", grant, busy, done));

    // All sources held: 001, 010, 100, then 001 again
    reset = 1'b0;
    step();
    reset = 1'b1;
    m_ptr = 0;
    req   = 3'b111;
    step();
    for (int f = 0; f < 3; f++) begin
      src = rr_pick(req, m_ptr);
      run_frame(src, FULL_K, 1'b0);
      m_ptr = (src + 1) % NREQ;
      step();
    end
    src = rr_pick(req, m_ptr);
    check("fourth_grant", grant == NREQ'(1 << src),
          $sformatf("got %b want %b", grant, NREQ'(1 << src)));

    // Reset at the cycle pixel 5000 is plotted, then restart from (0,0)
    run_frame(src, 5000 + ROM_LAT + 1, 1'b0);
    check("pix5000", x == 8'd40 && y == 7'd31,
          $sformatf("got (%0d,%0d) want (40,31)", x, y));
    reset = 1'b0;
    req   = '0;
    step();
    check_zero("midframe_reset");
    reset = 1'b1;
    req   = 3'b001;
    step();
    run_frame(0, ROM_LAT + 1 + 200, 1'b0);
    reset = 1'b0;
    step();
    check_zero("final_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
